mmio_timer_irq: RTL and testbench
=================================

// Module: mmio_timer_irq
// PURPOSE
//  Memory-mapped multi-channel timer/interrupt peripheral on the CPU data bus (peripheral space, addr[30]=1).
//  Generalises the single fixed timer: NUM_CH independent reload timers, shared prescaler, per-channel
//  one-shot/periodic mode, masked and aggregated into one level irqout. irqout drives the CPU IRQ input.
// PARAMETERS
//  NUM_CH     4             number of timer channels, 1..8
//  CNT_W      32            counter/reload width, 8..32; reads zero-extended to 32 bits
//  PRESC_W    16            prescaler register width, 1..32
//  BASE_ADDR  32'h40000100  block base; decode when addr[31:8] == BASE_ADDR[31:8]
// PORTS
//  clk     in   1   system clock
//  reset   in   1   asynchronous, active-high reset
//  rd      in   1   bus read strobe (already gated with addr[30])
//  wr      in   1   bus write strobe (already gated with addr[30])
//  addr    in   32  byte address, word aligned; addr[1:0] ignored
//  wdata   in   32  write data
//  rdata   out  32  read data, combinational; 32'h0 when !rd or address not decoded
//  irqout  out  1   level interrupt = |(PEND & MASK & IE[ch])
// BEHAVIOUR
//  Register map (offset = addr[7:0]); channel c at c*16:
//   +0 TH  reload value (CNT_W)     +4 TL counter (CNT_W)
//   +8 TCON bit0 EN, bit1 IE, bit2 ONESHOT; other bits read 0
//   0x80 PEND  per-channel status, read; write-1-to-clear
//   0x84 MASK  per-channel global mask; 0x88 PRESC (PRESC_W)
//   0x8C PCNT  prescaler count, read-only. Unmapped offsets/channels >= NUM_CH: reads 0, writes ignored.
//  Reset (async): TH=TL=0, TCON=0, PEND=0, MASK=0, PRESC=0, PCNT=0; rdata=0 when rd=0, irqout=0.
//  Prescaler: PCNT increments every clk; when PCNT==PRESC, tick=1 that cycle and PCNT<=0 next.
//   PRESC=0 -> tick every cycle. Write to PRESC also clears PCNT.
//  Channel counting, on tick with EN=1:
//   TL != all-ones: TL<=TL+1.
//   TL == all-ones (overflow): TL<=TH, PEND[c]<=1; if ONESHOT, EN<=0 same edge.
//  Writes take effect on the clk edge where wr=1; single-cycle, no wait states.
//  Simultaneous events (same edge):
//   bus write to TL vs count/overflow: bus write wins for TL; overflow still sets PEND.
//   W1C of PEND[c] vs new overflow of c: set wins (PEND[c]=1).
//   bus write to TCON vs one-shot EN clear: bus write wins.
//  irqout combinational from registered PEND/MASK/IE; asserts the cycle after the overflow edge;
//   stays high until PEND cleared (W1C) or IE/MASK cleared. No edge pulse.
//  rd and wr both high: write performed, rdata shows pre-write value.
//  Reset mid-count: all state returns to reset values immediately; no pending IRQ survives.
//  CNT_W<32: wdata upper bits dropped on TH/TL writes.
// STRUCTURE
//  Package mmio_timer_pkg: offset constants (OFF_TH/TL/TCON, OFF_PEND/MASK/PRESC/PCNT, CH_STRIDE=16),
//   TCON bit indices (TCON_EN/IE/ONESHOT).
//  Sub-module timer_channel (one per channel, generate loop): TH/TL/TCON regs, overflow detect,
//   outputs ovf pulse and IE; top holds prescaler, PEND/MASK, decode and read mux.
// TESTING
//  1 Reset: assert reset mid-count with EN=1 -> all regs read 0, irqout=0 within the same cycle.
//  2 Periodic: CNT_W=32, PRESC=0, TH=0xFFFFFFFC, TL=0xFFFFFFFC, TCON=3, MASK=1 -> overflow after
//    4 ticks, TL reloads 0xFFFFFFFC, irqout high from cycle 5; W1C PEND=1 -> irqout low next cycle.
//  3 Prescaler: PRESC=2, TL=0 EN=1 -> TL increments every 3rd clk; after 9 clks TL=3.
//  4 One-shot: TCON=7, TL=all-ones -> one tick overflows, EN reads 0, TL stays TH, PEND[0]=1.
//  5 Collisions: W1C PEND and overflow same edge -> PEND stays 1; TL write 0x10 on overflow edge
//    -> TL=0x10, PEND=1.
//  6 Multi-channel/mask: ch1 and ch3 overflow, MASK=0b0010 -> irqout follows ch1 only;
//    PEND reads 0b1010; read of offset 0x90 and ch>=NUM_CH -> 0.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// Shared register-map offsets and TCON bit positions for the mmio_timer_irq peripheral.
package mmio_timer_pkg;

    localparam logic [7:0] OFF_TH    = 8'h00;
    localparam logic [7:0] OFF_TL    = 8'h04;
    localparam logic [7:0] OFF_TCON  = 8'h08;
    localparam logic [7:0] OFF_PEND  = 8'h80;
    localparam logic [7:0] OFF_MASK  = 8'h84;
    localparam logic [7:0] OFF_PRESC = 8'h88;
    localparam logic [7:0] OFF_PCNT  = 8'h8C;

    localparam int CH_STRIDE = 16;

    localparam int TCON_EN      = 0;
    localparam int TCON_IE      = 1;
    localparam int TCON_ONESHOT = 2;
    localparam int TCON_W       = 3;

endpackage

// File: rtl/timer_channel.sv
// One reload timer channel: TH/TL/TCON registers, counting on prescaler ticks,
// overflow pulse generation and one-shot auto-disable.
module timer_channel
    import mmio_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              wr_th,
    input  logic              wr_tl,
    input  logic              wr_tcon,
    input  logic [31:0]       wdata,
    output logic [CNT_W-1:0]  th,
    output logic [CNT_W-1:0]  tl,
    output logic [TCON_W-1:0] tcon,
    output logic              ovf,
    output logic              ie
);

    logic en;
    logic oneshot;
    logic unused_wdata;

    assign en           = tcon[TCON_EN];
    assign oneshot      = tcon[TCON_ONESHOT];
    assign ie           = tcon[TCON_IE];
    assign ovf          = tick && en && (tl == {CNT_W{1'b1}});
    assign unused_wdata = ^wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th <= '0;
        end else if (wr_th) begin
            th <= wdata[CNT_W-1:0];
        end
    end

    // A bus write to TL takes priority over both counting and reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tl <= '0;
        end else if (wr_tl) begin
            tl <= wdata[CNT_W-1:0];
        end else if (ovf) begin
            tl <= th;
        end else if (tick && en) begin
            tl <= tl + CNT_W'(1);
        end
    end

    // A bus write to TCON overrides the one-shot self-disable on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcon <= '0;
        end else if (wr_tcon) begin
            tcon <= wdata[TCON_W-1:0];
        end else if (ovf && oneshot) begin
            tcon[TCON_EN] <= 1'b0;
        end
    end

endmodule

// File: rtl/mmio_timer_irq.sv
// Memory-mapped multi-channel timer with shared prescaler, pending/mask registers
// and a single aggregated level interrupt.
module mmio_timer_irq
    import mmio_timer_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 32,
    parameter int          PRESC_W   = 16,
    parameter logic [31:0] BASE_ADDR = 32'h40000100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout
);

    logic [7:0]         offset;
    logic               hit;
    logic               ch_hit;
    logic [2:0]         ch_idx;
    logic [7:0]         reg_off;
    logic               unused_addr;

    logic [NUM_CH-1:0]  pend;
    logic [NUM_CH-1:0]  mask;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;
    logic               tick;

    logic               wr_pend;
    logic               wr_mask;
    logic               wr_presc;

    logic [CNT_W-1:0]   th_q   [NUM_CH];
    logic [CNT_W-1:0]   tl_q   [NUM_CH];
    logic [TCON_W-1:0]  tcon_q [NUM_CH];
    logic [NUM_CH-1:0]  ovf;
    logic [NUM_CH-1:0]  ie;

    assign offset      = addr[7:0];
    assign hit         = (addr[31:8] == BASE_ADDR[31:8]);
    assign ch_hit      = hit && ({24'b0, offset} < 32'(NUM_CH * CH_STRIDE));
    assign ch_idx      = offset[6:4];
    assign reg_off     = {4'h0, offset[3:0]};
    assign unused_addr = ^addr[1:0];

    assign wr_pend  = wr && hit && (offset == OFF_PEND);
    assign wr_mask  = wr && hit && (offset == OFF_MASK);
    assign wr_presc = wr && hit && (offset == OFF_PRESC);

    assign tick = (pcnt == presc);

    // Writing PRESC restarts the prescaler so the new period begins cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            pcnt  <= '0;
        end else begin
            if (wr_presc) begin
                presc <= wdata[PRESC_W-1:0];
            end
            if (wr_presc || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PRESC_W'(1);
            end
        end
    end

    // A fresh overflow beats a write-1-to-clear of the same bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
            mask <= '0;
        end else begin
            pend <= (pend & ~(wr_pend ? wdata[NUM_CH-1:0] : '0)) | ovf;
            if (wr_mask) begin
                mask <= wdata[NUM_CH-1:0];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel;

        assign sel = wr && ch_hit && (ch_idx == 3'(c));

        timer_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .wr_th   (sel && (reg_off == OFF_TH)),
            .wr_tl   (sel && (reg_off == OFF_TL)),
            .wr_tcon (sel && (reg_off == OFF_TCON)),
            .wdata   (wdata),
            .th      (th_q[c]),
            .tl      (tl_q[c]),
            .tcon    (tcon_q[c]),
            .ovf     (ovf[c]),
            .ie      (ie[c])
        );
    end

    assign irqout = |(pend & mask & ie);

    always_comb begin
        rdata = 32'h0;
        if (rd && hit) begin
            if (ch_hit) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_idx == 3'(c)) begin
                        case (reg_off)
                            OFF_TH:   rdata = 32'(th_q[c]);
                            OFF_TL:   rdata = 32'(tl_q[c]);
                            OFF_TCON: rdata = 32'(tcon_q[c]);
                            default:  rdata = 32'h0;
                        endcase
                    end
                end
            end else begin
                case (offset)
                    OFF_PEND:  rdata = 32'(pend);
                    OFF_MASK:  rdata = 32'(mask);
                    OFF_PRESC: rdata = 32'(presc);
                    OFF_PCNT:  rdata = 32'(pcnt);
                    default:   rdata = 32'h0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmio_timer_irq.sv
// Directed self-checking bench for mmio_timer_irq: reset, periodic, prescaler,
// one-shot, collision and multi-channel/mask behaviour with hand-computed values.
module tb_mmio_timer_irq;

    localparam logic [31:0] BASE   = 32'h40000100;
    localparam logic [31:0] A_PEND = BASE + 32'h80;
    localparam logic [31:0] A_MASK = BASE + 32'h84;
    localparam logic [31:0] A_PRSC = BASE + 32'h88;
    localparam logic [31:0] A_PCNT = BASE + 32'h8C;

    logic        clk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irqout;

    int total = 0;
    int bad   = 0;

    mmio_timer_irq #(
        .NUM_CH    (4),
        .CNT_W     (32),
        .PRESC_W   (16),
        .BASE_ADDR (BASE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .irqout (irqout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] ch_addr(input int c, input logic [7:0] off);
        return BASE + 32'(c * 16) + {24'b0, off};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; the write lands on the following rising edge.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        rd   = 1'b1;
        #1;
        check_output(tag, rdata, exp);
        rd   = 1'b0;
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check_output(tag, {31'b0, irqout}, {31'b0, exp});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;

        // Reset values
        @(negedge clk);
        check_reg("rst_tl0",   ch_addr(0, 8'h04), 32'h0);
        check_reg("rst_tcon0", ch_addr(0, 8'h08), 32'h0);
        check_reg("rst_pend",  A_PEND, 32'h0);
        check_reg("rst_mask",  A_MASK, 32'h0);
        check_reg("rst_presc", A_PRSC, 32'h0);
        check_reg("rst_pcnt",  A_PCNT, 32'h0);
        check_irq("rst_irq", 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Reset asserted while channel 0 is running with an interrupt pending
        apply_stimulus(A_MASK, 32'h1);
        apply_stimulus(ch_addr(0, 8'h04), 32'hFFFFFFFF);
        apply_stimulus(ch_addr(0, 8'h08), 32'h3);
        @(negedge clk);
        check_irq("midrst_irq_before", 1'b1);
        reset = 1'b1;
        #1;
        check_irq("midrst_irq_after", 1'b0);
        check_reg("midrst_tl0",   ch_addr(0, 8'h04), 32'h0);
        check_reg("midrst_tcon0", ch_addr(0, 8'h08), 32'h0);
        check_reg("midrst_pend",  A_PEND, 32'h0);
        check_reg("midrst_mask",  A_MASK, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Periodic reload with PRESC=0
        apply_stimulus(A_MASK, 32'h1);
        apply_stimulus(ch_addr(0, 8'h00), 32'hFFFFFFFC);
        apply_stimulus(ch_addr(0, 8'h04), 32'hFFFFFFFC);
        apply_stimulus(ch_addr(0, 8'h08), 32'h3);
        check_reg("per_tl_start", ch_addr(0, 8'h04), 32'hFFFFFFFC);
        repeat (3) @(negedge clk);
        check_reg("per_tl_top", ch_addr(0, 8'h04), 32'hFFFFFFFF);
        check_irq("per_irq_pre", 1'b0);
        @(negedge clk);
        check_reg("per_tl_reload", ch_addr(0, 8'h04), 32'hFFFFFFFC);
        check_reg("per_pend", A_PEND, 32'h1);
        check_irq("per_irq_high", 1'b1);
        apply_stimulus(A_PEND, 32'h1);
        check_irq("per_irq_w1c", 1'b0);
        check_reg("per_pend_w1c", A_PEND, 32'h0);
        apply_stimulus(ch_addr(0, 8'h08), 32'h0);

        // Prescaler of 3 clocks per tick
        apply_stimulus(A_PRSC, 32'h2);
        apply_stimulus(ch_addr(0, 8'h04), 32'h0);
        apply_stimulus(ch_addr(0, 8'h08), 32'h1);
        @(negedge clk);
        check_reg("psc_tl_1",   ch_addr(0, 8'h04), 32'h1);
        check_reg("psc_pcnt_0", A_PCNT, 32'h0);
        repeat (5) @(negedge clk);
        check_reg("psc_tl_2",   ch_addr(0, 8'h04), 32'h2);
        check_reg("psc_pcnt_2", A_PCNT, 32'h2);
        repeat (3) @(negedge clk);
        check_reg("psc_tl_3",   ch_addr(0, 8'h04), 32'h3);
        check_reg("psc_presc",  A_PRSC, 32'h2);
        apply_stimulus(ch_addr(0, 8'h08), 32'h0);
        apply_stimulus(A_PRSC, 32'h0);

        // One-shot overflow disables the channel
        apply_stimulus(ch_addr(0, 8'h00), 32'h55);
        apply_stimulus(ch_addr(0, 8'h04), 32'hFFFFFFFF);
        apply_stimulus(ch_addr(0, 8'h08), 32'h7);
        @(negedge clk);
        check_reg("os_tcon", ch_addr(0, 8'h08), 32'h6);
        check_reg("os_tl",   ch_addr(0, 8'h04), 32'h55);
        check_reg("os_pend", A_PEND, 32'h1);
        check_irq("os_irq", 1'b1);
        repeat (2) @(negedge clk);
        check_reg("os_tl_hold", ch_addr(0, 8'h04), 32'h55);
        apply_stimulus(A_PEND, 32'h1);
        check_reg("os_pend_clr", A_PEND, 32'h0);
        check_irq("os_irq_clr", 1'b0);

        // Same-edge collisions
        apply_stimulus(ch_addr(0, 8'h00), 32'h0);
        apply_stimulus(ch_addr(0, 8'h04), 32'hFFFFFFFE);
        apply_stimulus(ch_addr(0, 8'h08), 32'h3);
        @(negedge clk);
        apply_stimulus(A_PEND, 32'h1);
        check_reg("col_w1c_pend", A_PEND, 32'h1);
        check_reg("col_w1c_tl",   ch_addr(0, 8'h04), 32'h0);
        check_irq("col_w1c_irq", 1'b1);
        apply_stimulus(A_PEND, 32'h1);
        apply_stimulus(ch_addr(0, 8'h04), 32'hFFFFFFFF);
        apply_stimulus(ch_addr(0, 8'h04), 32'h10);
        check_reg("col_tl_wr",   ch_addr(0, 8'h04), 32'h10);
        check_reg("col_tl_pend", A_PEND, 32'h1);
        @(negedge clk);
        check_reg("col_tl_next", ch_addr(0, 8'h04), 32'h11);
        apply_stimulus(ch_addr(0, 8'h08), 32'h0);
        apply_stimulus(A_PEND, 32'h1);
        check_reg("col_pend_clr", A_PEND, 32'h0);

        // Read and write in the same cycle returns the old value
        addr  = ch_addr(0, 8'h00);
        wdata = 32'h1234;
        rd    = 1'b1;
        wr    = 1'b1;
        #1;
        check_output("rdwr_old", rdata, 32'h0);
        @(negedge clk);
        rd = 1'b0;
        wr = 1'b0;
        check_reg("rdwr_new", ch_addr(0, 8'h00), 32'h1234);

        // Two channels, mask selects which one drives the interrupt
        apply_stimulus(A_MASK, 32'h2);
        apply_stimulus(ch_addr(1, 8'h00), 32'h0);
        apply_stimulus(ch_addr(1, 8'h04), 32'hFFFFFFFF);
        apply_stimulus(ch_addr(3, 8'h04), 32'hFFFFFFFF);
        apply_stimulus(ch_addr(1, 8'h08), 32'h3);
        apply_stimulus(ch_addr(3, 8'h08), 32'h3);
        @(negedge clk);
        check_reg("mc_pend", A_PEND, 32'hA);
        check_irq("mc_irq_ch1", 1'b1);
        apply_stimulus(A_PEND, 32'h2);
        check_reg("mc_pend_ch3", A_PEND, 32'h8);
        check_irq("mc_irq_masked", 1'b0);
        apply_stimulus(A_MASK, 32'h8);
        check_irq("mc_irq_ch3", 1'b1);
        apply_stimulus(ch_addr(3, 8'h08), 32'h1);
        check_irq("mc_irq_ie_off", 1'b0);

        // Decode boundaries
        apply_stimulus(ch_addr(4, 8'h00), 32'hDEAD);
        check_reg("dec_ch4_th", ch_addr(4, 8'h00), 32'h0);
        check_reg("dec_th0_kept", ch_addr(0, 8'h00), 32'h1234);
        check_reg("dec_0x90", BASE + 32'h90, 32'h0);
        check_reg("dec_other_base", 32'h40000214, 32'h0);
        apply_stimulus(ch_addr(1, 8'h08), 32'hFFFFFFF9);
        check_reg("dec_tcon_bits", ch_addr(1, 8'h08), 32'h1);
        addr = A_PEND;
        rd   = 1'b0;
        #1;
        check_output("dec_no_rd", rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
